// File: rtl/ioctl_rom_router.sv
// Routes the data_io ioctl byte stream into NPORTS toggle-handshake SDRAM write ports,
// with per-region rebasing, byte-lane steering and sticky download status flags.
module ioctl_rom_router #(
  parameter int                   NPORTS      = 2,
  parameter int                   AW          = 25,
  parameter int                   PORT_AW     = 23,
  parameter int                   FIFO_DEPTH  = 4,
  parameter int                   ROM_INDEX   = 0,
  parameter logic [NPORTS*AW-1:0] REGION_BASE = {25'h0006000, 25'h000C000},
  parameter logic [NPORTS*AW-1:0] REGION_SIZE = {25'h0006000, 25'h0004000},
  parameter logic [NPORTS-1:0]    MODE        = 2'b10,
  parameter int                   SPLIT       = 13,
  parameter int                   ACK_TIMEOUT = 255
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        ioctl_download,
  input  logic [7:0]                  ioctl_index,
  input  logic                        ioctl_wr,
  input  logic [AW-1:0]               ioctl_addr,
  input  logic [7:0]                  ioctl_dout,
  output logic [NPORTS-1:0]           port_req,
  input  logic [NPORTS-1:0]           port_ack,
  output logic [NPORTS*PORT_AW-1:0]   port_a,
  output logic [NPORTS*2-1:0]         port_ds,
  output logic [NPORTS*16-1:0]        port_d,
  output logic [NPORTS-1:0]           port_we,
  output logic                        busy,
  output logic                        rom_loaded,
  output logic                        err_overflow,
  output logic                        err_range,
  output logic                        err_timeout
);

  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PS  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int TW  = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
  localparam int EW  = AW + 8;

  // SYNC: align req to ack | IDLE: decode FIFO head | WAIT: one port outstanding
  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]                state_q, state_d;
  logic                      wr_last_q, dl_last_q;
  logic [EW-1:0]             fifo_q [FIFO_DEPTH];
  logic [FAW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FAW:0]              count_q, count_d;
  logic [NPORTS-1:0]         req_q, req_d, we_q, we_d;
  logic [NPORTS*PORT_AW-1:0] a_q, a_d;
  logic [NPORTS*2-1:0]       ds_q, ds_d;
  logic [NPORTS*16-1:0]      d_q, d_d;
  logic [PS-1:0]             sel_q, sel_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      loaded_q, loaded_d, ovf_q, ovf_d, range_q, range_d, tmo_q, tmo_d;

  logic                      push, push_ok, pop, fifo_empty, fifo_full;
  logic [AW-1:0]             head_addr, rel;
  logic [7:0]                head_data;
  logic                      hit, hit_mode, cur_ack, cur_req;
  logic [PS-1:0]             hit_idx;
  logic [AW-2:0]             lin_src, mrg_src;
  logic [AW+PORT_AW-1:0]     lin_ext, mrg_ext;
  logic [PORT_AW-1:0]        map_a;
  logic [1:0]                map_ds;
  logic                      unused_ext;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (FAW+1)'(FIFO_DEPTH));
  assign push       = ioctl_wr & ~wr_last_q & ioctl_download & (ioctl_index == 8'(ROM_INDEX));
  // a pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign push_ok    = push & (~fifo_full | pop);
  assign {head_addr, head_data} = fifo_q[rptr_q];

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_mode = 1'b0;
    rel      = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if ((head_addr >= REGION_BASE[i*AW +: AW]) &&
          ((head_addr - REGION_BASE[i*AW +: AW]) < REGION_SIZE[i*AW +: AW])) begin
        hit      = 1'b1;
        hit_idx  = PS'(i);
        hit_mode = MODE[i];
        rel      = head_addr - REGION_BASE[i*AW +: AW];
      end
    end
  end

  assign lin_src    = rel[AW-1:1];
  assign mrg_src    = {rel[AW-1:SPLIT+2], rel[SPLIT-1:0], rel[SPLIT+1]};
  assign lin_ext    = {{(PORT_AW+1){1'b0}}, lin_src};
  assign mrg_ext    = {{(PORT_AW+1){1'b0}}, mrg_src};
  assign unused_ext = ^{lin_ext, mrg_ext};
  assign map_a      = hit_mode ? mrg_ext[PORT_AW-1:0] : lin_ext[PORT_AW-1:0];
  assign map_ds     = hit_mode ? {rel[SPLIT], ~rel[SPLIT]} : {rel[0], ~rel[0]};

  always_comb begin
    cur_ack = 1'b0;
    cur_req = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (PS'(i) == sel_q) begin
        cur_ack = port_ack[i];
        cur_req = req_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    a_d     = a_q;
    ds_d    = ds_q;
    d_d     = d_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    range_d = range_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    case (state_q)
      ST_SYNC: begin
        req_d   = port_ack;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (hit) begin
            for (int i = 0; i < NPORTS; i++) begin
              if (PS'(i) == hit_idx) begin
                a_d[i*PORT_AW +: PORT_AW] = map_a;
                ds_d[i*2 +: 2]            = map_ds;
                d_d[i*16 +: 16]           = {head_data, head_data};
                req_d[i]                  = ~req_q[i];
                we_d[i]                   = 1'b1;
              end
            end
            sel_d   = hit_idx;
            timer_d = '0;
            state_d = ST_WAIT;
          end else begin
            pop     = 1'b1;
            range_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cur_ack == cur_req) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
          for (int i = 0; i < NPORTS; i++) if (PS'(i) == sel_q) we_d[i] = 1'b0;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          pop     = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
          for (int i = 0; i < NPORTS; i++) begin
            if (PS'(i) == sel_q) begin
              we_d[i]  = 1'b0;
              req_d[i] = port_ack[i];
            end
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    wptr_d   = push_ok ? wptr_q + FAW'(1) : wptr_q;
    rptr_d   = pop ? rptr_q + FAW'(1) : rptr_q;
    count_d  = count_q;
    if (push_ok && !pop) count_d = count_q + (FAW+1)'(1);
    if (!push_ok && pop) count_d = count_q - (FAW+1)'(1);
    ovf_d    = ovf_q | (push & ~push_ok);
    loaded_d = loaded_q | (dl_last_q & ~ioctl_download & (ioctl_index == 8'(ROM_INDEX)));
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) fifo_q[wptr_q] <= {ioctl_addr, ioctl_dout};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SYNC;
      wr_last_q <= 1'b0;
      dl_last_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      req_q     <= '0;
      we_q      <= '0;
      a_q       <= '0;
      ds_q      <= '0;
      d_q       <= '0;
      sel_q     <= '0;
      timer_q   <= '0;
      loaded_q  <= 1'b0;
      ovf_q     <= 1'b0;
      range_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_last_q <= ioctl_wr;
      dl_last_q <= ioctl_download;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      req_q     <= req_d;
      we_q      <= we_d;
      a_q       <= a_d;
      ds_q      <= ds_d;
      d_q       <= d_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      loaded_q  <= loaded_d;
      ovf_q     <= ovf_d;
      range_q   <= range_d;
      tmo_q     <= tmo_d;
    end
  end

  assign port_req     = req_q;
  assign port_we      = we_q;
  assign port_a       = a_q;
  assign port_ds      = ds_q;
  assign port_d       = d_q;
  assign busy         = !fifo_empty || (state_q == ST_WAIT);
  assign rom_loaded   = loaded_q;
  assign err_overflow = ovf_q;
  assign err_range    = range_q;
  assign err_timeout  = tmo_q;

endmodule
